dcs_cmd_tx: RTL and testbench
=============================

DCS_CMD_TX -- requirements
Module: dcs_cmd_tx

Interface
REQ-001 Parameter MAX_BYTES, default 16: maximum payload bytes per packet; legal range 4..64, multiple of 4.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles after each packet before the next request is accepted; legal range 0..255.
REQ-003 clkrx  input  1  clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_dt  input  8  DSI data type.
REQ-008 req_wc  input  16  payload byte count.
REQ-009 req_data  input  8*MAX_BYTES  payload bytes; byte k is at bits [8k+7:8k], and byte 0 is the DCS register (e.g. 0xB5).
REQ-010 tx_cmd  output  24  packet header {wc[15:8], wc[7:0], dt}.
REQ-011 tx_cmd_valid  output  1  header strobe, one cycle.
REQ-012 tx_payload  output  32  payload word; the lowest-numbered byte is in [7:0].
REQ-013 tx_payload_valid  output  1  payload word strobe.
REQ-014 tx_payload_last  output  1  final payload word of the packet.
REQ-015 req_err  output  1  one-cycle pulse when a request is rejected.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, HDR, PAY and GAP; req_ready SHALL equal 1 only in IDLE.
REQ-018 A request is accepted on a clock edge where req_valid=1 and req_ready=1; req_dt, req_wc and req_data SHALL be captured on that edge.
REQ-019 A request is valid only if req_dt is 0x29 or 0x39 and 1 <= req_wc <= MAX_BYTES.
REQ-020 A valid request SHALL move the FSM to HDR.
REQ-021 An invalid request SHALL pulse req_err in the next cycle, produce no output strobes, and move the FSM directly to GAP.
REQ-022 HDR SHALL last exactly 1 cycle, with tx_cmd_valid=1 and tx_cmd={wc_hi, wc_lo, dt}. It is entered the cycle after acceptance (latency 1).
REQ-023 PAY SHALL emit ceil(wc/4) words on consecutive cycles, starting the cycle after HDR, with tx_payload_valid=1 on each word.
REQ-024 Word n SHALL carry bytes 4n..4n+3; byte positions at or beyond wc in the final word SHALL be 0x00.
REQ-025 tx_payload_last SHALL be 1 only on the final word; when wc<=4 that is the single word, which therefore has valid and last together.
REQ-026 tx_cmd_valid and tx_payload_valid SHALL never be high in the same cycle.
REQ-027 GAP SHALL count GAP_CYCLES cycles, then return to IDLE; with GAP_CYCLES=0, PAY or a rejection SHALL return to IDLE directly.
REQ-028 Word counter: 5 bits minimum; gap counter: 8 bits. Neither counter SHALL wrap: the word counter stops at the final word, and the gap counter stops at GAP_CYCLES.
REQ-029 When not strobed, tx_cmd and tx_payload SHALL hold their last values; they are don't-care to consumers.
REQ-030 Changes on req_* inputs while not in IDLE SHALL be ignored.

Reset
REQ-031 On rst_n low, outputs SHALL immediately take: FSM=IDLE, counters=0, tx_cmd=0, tx_payload=0, all strobes=0, req_err=0, busy=0.
REQ-032 In reset, req_ready SHALL be 0. After rst_n deasserts it SHALL be 1 from the first clock edge.
REQ-033 Reset during HDR or PAY SHALL abort the packet with no further strobes; a partially sent packet is not resumed.

Configuration
REQ-034 With macro DCS_TX_CHKSUM_EN defined, the block SHALL add output tx_chksum (16 bits).
REQ-035 tx_chksum SHALL equal the mod-2^16 sum of the wc payload bytes; padding bytes are excluded.
REQ-036 tx_chksum SHALL be valid on the cycle tx_payload_last=1 and SHALL hold until the next accepted request, which clears the sum to 0.
REQ-037 Without DCS_TX_CHKSUM_EN, the port and its adder SHALL be absent and all other behaviour unchanged.

Verification
REQ-038 dt=0x39, wc=3, bytes B5,CC,34 -> tx_cmd=0x000339 one cycle after accept; next cycle tx_payload=0x0034CCB5 with valid=1 and last=1; tx_chksum=0x01B5.
REQ-039 dt=0x29, wc=3, bytes B1,12,34 -> tx_cmd=0x000329; tx_payload=0x003412B1 with last=1.
REQ-040 dt=0x39, wc=9, bytes 0x01..0x09 -> 3 words, 0x04030201, 0x08070605, 0x00000009; last only on word 3.
REQ-041 Invalid requests dt=0x15, wc=0 and wc=17 -> req_err pulse, no tx strobes, req_ready returns after GAP_CYCLES+1 cycles.
REQ-042 req_valid held high continuously, GAP_CYCLES=2 -> next accept occurs exactly 3 cycles after the previous last word (2 GAP cycles, then 1 IDLE cycle).
REQ-043 rst_n asserted during word 2 of a wc=16 packet -> all strobes 0 immediately; req_ready=1 on the first edge after release.

Source files
------------

// File: rtl/dcs_cmd_tx.sv
// -----------------------------------------------------------------------------
// dcs_cmd_tx
// Turns one DCS long-write request into a DSI packet. The packet is a one-cycle
// 24-bit header strobe followed by ceil(wc/4) consecutive 32-bit payload words.
// After each packet, and after each rejected request, the block idles for
// GAP_CYCLES cycles before it accepts the next request.
//
// Parameters
//   MAX_BYTES   maximum payload bytes per packet (4..64, multiple of 4)
//   GAP_CYCLES  idle cycles after a packet or rejection (0..255)
//
// Optional feature
//   DCS_TX_CHKSUM_EN  when defined, adds tx_chksum: the 16-bit sum of the
//                     payload bytes. Padding bytes are not included.
//
// Ports
//   clkrx             clock, rising edge
//   rst_n             asynchronous active-low reset
//   req_valid/ready   request handshake; ready is high only in IDLE
//   req_dt            DSI data type (0x29 or 0x39 accepted)
//   req_wc            payload byte count (1..MAX_BYTES accepted)
//   req_data          payload bytes, byte k at [8k+7:8k]
//   tx_cmd            header {wc_hi, wc_lo, dt}, qualified by tx_cmd_valid
//   tx_payload        payload word, lowest byte in [7:0], qualified by
//                     tx_payload_valid; tx_payload_last marks the final word
//   req_err           one-cycle pulse after a rejected request
//   busy              high whenever the block is not idle
//   tx_chksum         (optional) payload byte sum, valid with last word
// -----------------------------------------------------------------------------
module dcs_cmd_tx #(
    parameter int MAX_BYTES  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clkrx,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [7:0]             req_dt,
    input  logic [15:0]            req_wc,
    input  logic [8*MAX_BYTES-1:0] req_data,
    output logic [23:0]            tx_cmd,
    output logic                   tx_cmd_valid,
    output logic [31:0]            tx_payload,
    output logic                   tx_payload_valid,
    output logic                   tx_payload_last,
    output logic                   req_err,
    output logic                   busy
`ifdef DCS_TX_CHKSUM_EN
    ,
    output logic [15:0]            tx_chksum
`endif
);

    localparam int          NWORDS    = MAX_BYTES / 4;
    localparam logic [15:0] MAX_WC    = 16'(MAX_BYTES);
    localparam logic [7:0]  GAP_LIMIT = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Only long DCS writes with a payload that fits the buffer are accepted.
    function automatic logic is_valid_req(input logic [7:0] dt, input logic [15:0] wc);
        return ((dt == 8'h29) || (dt == 8'h39)) && (wc >= 16'd1) && (wc <= MAX_WC);
    endfunction

    // Index of the final payload word: ceil(wc/4) - 1.
    function automatic logic [4:0] last_idx_of(input logic [15:0] wc);
        logic [15:0] nw;
        nw = (wc + 16'd3) >> 2;
        return 5'(nw - 16'd1);
    endfunction

`ifdef DCS_TX_CHKSUM_EN
    // Sum of the four bytes of one payload word. Padding bytes are already
    // zero, so they add nothing.
    function automatic logic [15:0] byte_sum4(input logic [31:0] w);
        return {8'h00, w[7:0]} + {8'h00, w[15:8]} + {8'h00, w[23:16]} + {8'h00, w[31:24]};
    endfunction
`endif

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [4:0]                    word_idx_r;
    logic [4:0]                    word_idx_nxt_s;
    logic [4:0]                    last_idx_r;
    logic [7:0]                    gap_cnt_r;
    logic [7:0]                    gap_cnt_nxt_s;
    logic [NWORDS-1:0][31:0]       data_r;
    logic [8*MAX_BYTES-1:0]        masked_s;
    logic [31:0]                   word_sel_s;
    logic                          accept_s;
    logic                          req_ok_s;

    logic                          req_ready_r;
    logic                          busy_r;
    logic [23:0]                   tx_cmd_r;
    logic                          tx_cmd_valid_r;
    logic [31:0]                   tx_payload_r;
    logic                          tx_payload_valid_r;
    logic                          tx_payload_last_r;
    logic                          req_err_r;

    assign accept_s = req_valid & req_ready_r;
    assign req_ok_s = is_valid_req(req_dt, req_wc);

    // Zero every byte at or beyond wc, so the final word arrives already padded.
    always_comb begin
        masked_s = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            masked_s[8*k +: 8] = ({16'd0, req_wc} > 32'(k)) ? req_data[8*k +: 8] : 8'h00;
        end
    end

    // Select the payload word that the next cycle will present.
    always_comb begin
        word_sel_s = 32'h0000_0000;
        for (int w = 0; w < NWORDS; w++) begin
            word_sel_s = word_sel_s | (data_r[w] & {32{word_idx_nxt_s == 5'(w)}});
        end
    end

    // Next-state and counter logic. Both counters saturate instead of wrapping.
    always_comb begin
        state_nxt_s    = state_r;
        word_idx_nxt_s = word_idx_r;
        gap_cnt_nxt_s  = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    word_idx_nxt_s = 5'd0;
                    gap_cnt_nxt_s  = 8'd0;
                    if (req_ok_s) begin
                        state_nxt_s = ST_HDR;
                    end else if (GAP_LIMIT == 8'd0) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_GAP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                state_nxt_s    = ST_PAY;
                word_idx_nxt_s = 5'd0;
            end
            ST_PAY: begin
                if (word_idx_r == last_idx_r) begin
                    gap_cnt_nxt_s = 8'd0;
                    if (GAP_LIMIT == 8'd0) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_GAP;
                    end
                end else begin
                    word_idx_nxt_s = word_idx_r + 5'd1;
                end
            end
            ST_GAP: begin
                if ((gap_cnt_r + 8'd1) >= GAP_LIMIT) begin
                    gap_cnt_nxt_s = GAP_LIMIT;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                word_idx_nxt_s = 5'd0;
                gap_cnt_nxt_s  = 8'd0;
            end
        endcase
    end

    // State, counters, captured request and all outputs. Each output is
    // registered from the next state, so it lines up with the state it marks.
    always_ff @(posedge clkrx or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= ST_IDLE;
            word_idx_r         <= 5'd0;
            last_idx_r         <= 5'd0;
            gap_cnt_r          <= 8'd0;
            data_r             <= '0;
            req_ready_r        <= 1'b0;
            busy_r             <= 1'b0;
            tx_cmd_r           <= 24'h00_0000;
            tx_cmd_valid_r     <= 1'b0;
            tx_payload_r       <= 32'h0000_0000;
            tx_payload_valid_r <= 1'b0;
            tx_payload_last_r  <= 1'b0;
            req_err_r          <= 1'b0;
        end else begin
            state_r            <= state_nxt_s;
            word_idx_r         <= word_idx_nxt_s;
            gap_cnt_r          <= gap_cnt_nxt_s;
            req_ready_r        <= (state_nxt_s == ST_IDLE);
            busy_r             <= (state_nxt_s != ST_IDLE);
            tx_cmd_valid_r     <= (state_nxt_s == ST_HDR);
            tx_payload_valid_r <= (state_nxt_s == ST_PAY);
            tx_payload_last_r  <= (state_nxt_s == ST_PAY) && (word_idx_nxt_s == last_idx_r);
            req_err_r          <= accept_s && !req_ok_s;
            // A rejected request leaves the header and buffer untouched, so
            // the outputs keep their last values.
            if (accept_s && req_ok_s) begin
                tx_cmd_r   <= {req_wc, req_dt};
                data_r     <= masked_s;
                last_idx_r <= last_idx_of(req_wc);
            end
            if (state_nxt_s == ST_PAY) begin
                tx_payload_r <= word_sel_s;
            end
        end
    end

`ifdef DCS_TX_CHKSUM_EN
    logic [15:0] chksum_r;

    // Add each word's bytes as the word is emitted. The sum is complete on
    // the last word, and it holds until the next handshake clears it.
    always_ff @(posedge clkrx or negedge rst_n) begin
        if (!rst_n) begin
            chksum_r <= 16'h0000;
        end else if (accept_s) begin
            chksum_r <= 16'h0000;
        end else if (state_nxt_s == ST_PAY) begin
            chksum_r <= chksum_r + byte_sum4(word_sel_s);
        end
    end

    assign tx_chksum = chksum_r;
`endif

    assign req_ready        = req_ready_r;
    assign busy             = busy_r;
    assign tx_cmd           = tx_cmd_r;
    assign tx_cmd_valid     = tx_cmd_valid_r;
    assign tx_payload       = tx_payload_r;
    assign tx_payload_valid = tx_payload_valid_r;
    assign tx_payload_last  = tx_payload_last_r;
    assign req_err          = req_err_r;

endmodule

// File: tb/tb_dcs_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_dcs_cmd_tx
// Self-checking bench for dcs_cmd_tx. It uses directed and random requests.
// For each request, a reference model derives the expected cycle-by-cycle
// output from the packet rules: the header, the padded payload words, the
// last flag, the gap timing and the byte sum. The request inputs are filled
// with random values while the block is busy.
// -----------------------------------------------------------------------------
module tb_dcs_cmd_tx;

    localparam int MB  = 16;
    localparam int GAP = 2;

    logic            clkrx;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [7:0]      req_dt;
    logic [15:0]     req_wc;
    logic [8*MB-1:0] req_data;
    logic [23:0]     tx_cmd;
    logic            tx_cmd_valid;
    logic [31:0]     tx_payload;
    logic            tx_payload_valid;
    logic            tx_payload_last;
    logic            req_err;
    logic            busy;
`ifdef DCS_TX_CHKSUM_EN
    logic [15:0]     tx_chksum;
`endif

    int              checks;
    int              failures;
    logic [23:0]     prev_hdr;
    logic [15:0]     prev_sum;

    dcs_cmd_tx #(.MAX_BYTES(MB), .GAP_CYCLES(GAP)) dut (
        .clkrx            (clkrx),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_dt           (req_dt),
        .req_wc           (req_wc),
        .req_data         (req_data),
        .tx_cmd           (tx_cmd),
        .tx_cmd_valid     (tx_cmd_valid),
        .tx_payload       (tx_payload),
        .tx_payload_valid (tx_payload_valid),
        .tx_payload_last  (tx_payload_last),
        .req_err          (req_err),
        .busy             (busy)
`ifdef DCS_TX_CHKSUM_EN
        ,
        .tx_chksum        (tx_chksum)
`endif
    );

    initial clkrx = 1'b0;
    always #5 clkrx = ~clkrx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Random inputs while busy. These must be ignored, and req_valid stays high.
    task automatic junk();
        req_valid = 1'b1;
        req_dt    = 8'($urandom);
        req_wc    = 16'($urandom_range(1, MB));
        req_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cmd_valid"}, {31'd0, tx_cmd_valid}, 32'd0);
        chk({tag, "_pay_valid"}, {31'd0, tx_payload_valid}, 32'd0);
        chk({tag, "_pay_last"},  {31'd0, tx_payload_last},  32'd0);
    endtask

    // Issue one request and check the full response up to the next idle cycle.
    task automatic send(input logic [7:0] dt, input logic [15:0] wc, input logic [8*MB-1:0] data);
        logic        ok;
        int          nw;
        int          n;
        int          k;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] sum;
        ok = ((dt == 8'h29) || (dt == 8'h39)) && (wc >= 16'd1) && (wc <= 16'(MB));
        n  = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            @(negedge clkrx);
            n++;
        end
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_dt    = dt;
        req_wc    = wc;
        req_data  = data;
        @(negedge clkrx);
        junk();
        sum = 16'h0000;
        if (ok) begin
            chk("hdr_valid", {31'd0, tx_cmd_valid}, 32'd1);
            chk("hdr_value", {8'd0, tx_cmd}, {8'd0, wc, dt});
            chk("hdr_no_pay", {31'd0, tx_payload_valid}, 32'd0);
            chk("hdr_err", {31'd0, req_err}, 32'd0);
            chk("hdr_busy", {31'd0, busy}, 32'd1);
            chk("hdr_ready", {31'd0, req_ready}, 32'd0);
            prev_hdr = {wc, dt};
            nw = (int'(wc) + 3) / 4;
            for (int i = 0; i < nw; i++) begin
                @(negedge clkrx);
                junk();
                w = 32'h0000_0000;
                for (int j = 0; j < 4; j++) begin
                    k = 4 * i + j;
                    b = (k < int'(wc)) ? data[8*k +: 8] : 8'h00;
                    w = w | ({24'd0, b} << (8 * j));
                    sum = sum + {8'h00, b};
                end
                chk("pay_valid", {31'd0, tx_payload_valid}, 32'd1);
                chk("pay_value", tx_payload, w);
                chk("pay_last", {31'd0, tx_payload_last}, (i == nw - 1) ? 32'd1 : 32'd0);
                chk("pay_no_cmd", {31'd0, tx_cmd_valid}, 32'd0);
`ifdef DCS_TX_CHKSUM_EN
                if (i == nw - 1) begin
                    chk("chksum_last", {16'd0, tx_chksum}, {16'd0, sum});
                end
`endif
            end
            prev_sum = sum;
        end else begin
            chk("rej_err", {31'd0, req_err}, 32'd1);
            chk_quiet("rej");
            chk("rej_ready", {31'd0, req_ready}, 32'd0);
            chk("rej_hdr_hold", {8'd0, tx_cmd}, {8'd0, prev_hdr});
            prev_sum = 16'h0000;
        end
        for (int g = (ok ? 0 : 1); g < GAP; g++) begin
            @(negedge clkrx);
            junk();
            chk("gap_ready", {31'd0, req_ready}, 32'd0);
            chk("gap_busy", {31'd0, busy}, 32'd1);
            chk("gap_err", {31'd0, req_err}, 32'd0);
            chk_quiet("gap");
            chk("gap_hdr_hold", {8'd0, tx_cmd}, {8'd0, prev_hdr});
        end
        @(negedge clkrx);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk_quiet("idle");
`ifdef DCS_TX_CHKSUM_EN
        chk("chksum_hold", {16'd0, tx_chksum}, {16'd0, prev_sum});
`endif
        req_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]      r_dt;
        logic [15:0]     r_wc;
        logic [8*MB-1:0] r_data;
        int              n;
        checks    = 0;
        failures  = 0;
        prev_hdr  = 24'h00_0000;
        prev_sum  = 16'h0000;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_dt    = 8'h00;
        req_wc    = 16'h0000;
        req_data  = '0;

        // Reset state
        #2;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, req_err}, 32'd0);
        chk("rst_cmd", {8'd0, tx_cmd}, 32'd0);
        chk("rst_pay", tx_payload, 32'd0);
        chk_quiet("rst");
        @(negedge clkrx);
        @(negedge clkrx);
        req_valid = 1'b1;
        req_dt    = 8'h39;
        req_wc    = 16'd2;
        rst_n     = 1'b1;
        #1;
        chk("rel_ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(negedge clkrx);
        chk("rel_ready_first_edge", {31'd0, req_ready}, 32'd1);
        chk("rel_no_accept", {31'd0, busy}, 32'd0);
        req_valid = 1'b0;

        // Directed packets and rejections
        send(8'h39, 16'd3, 128'h34CCB5);
        send(8'h29, 16'd3, 128'h3412B1);
        send(8'h39, 16'd9, 128'h09_0807_0605_0403_0201);
        send(8'h15, 16'd3, 128'hAABBCC);
        send(8'h39, 16'd0, 128'h11);
        send(8'h39, 16'd17, 128'h22);
        send(8'h29, 16'd1, 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_11F0);
        send(8'h39, 16'd4, 128'hDEADBEEF);
        send(8'h39, 16'd5, 128'hA5_DEADBEEF);
        send(8'h29, 16'd16, 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F);

        // Reset during the second payload word of a 16-byte packet
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            @(negedge clkrx);
            n++;
        end
        req_valid = 1'b1;
        req_dt    = 8'h39;
        req_wc    = 16'd16;
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clkrx);
        junk();
        @(negedge clkrx);
        @(negedge clkrx);
        chk("abort_in_word2", {31'd0, tx_payload_valid}, 32'd1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk_quiet("abort");
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_cmd", {8'd0, tx_cmd}, 32'd0);
        chk("abort_pay", tx_payload, 32'd0);
        @(negedge clkrx);
        @(negedge clkrx);
        rst_n = 1'b1;
        @(negedge clkrx);
        chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
        chk_quiet("abort_after");
        prev_hdr = 24'h00_0000;

        // Random requests
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 3))
                0:       r_dt = 8'h29;
                1:       r_dt = 8'h39;
                2:       r_dt = 8'($urandom);
                default: r_dt = 8'h39;
            endcase
            r_wc   = 16'($urandom_range(0, MB + 4));
            r_data = {$urandom, $urandom, $urandom, $urandom};
            send(r_dt, r_wc, r_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
